// File: rtl/alu32_sequencer.sv
// 32-bit add/sub/and/or sequenced over a shared 16-bit ALU in two or three passes.
// Carry/borrow between halves is chained through an optional fix-up pass on the high half.
module alu32_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_overflow,
  output logic        rsp_zero,
  output logic        rsp_negative
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_FIX  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  state_t      state_r;
  state_t      next_state_s;
  logic [1:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [15:0] lo_r;
  logic [15:0] hi_r;
  logic        c_lo_r;
  logic        c2_r;
  logic        c3_r;

  logic [15:0] alu_a_s;
  logic [15:0] alu_b_s;
  logic [1:0]  alu_op_s;
  logic        need_fix_s;
  logic [15:0] fin_hi_s;
  logic        fin_c2_s;
  logic        fin_c3_s;
  logic [31:0] fin_result_s;

  // Sub carry means "no borrow": the word borrows unless the high pass and the fix-up both don't.
  function automatic logic calc_carry(input logic [1:0] op, input logic c_lo,
                                      input logic c2, input logic c3);
    logic c;
    case (op)
      OP_ADD:  c = c2 | c3;
      OP_SUB:  c = c2 & (c_lo | c3);
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic calc_overflow(input logic [1:0] op, input logic a31,
                                         input logic b31, input logic r31);
    logic v;
    case (op)
      OP_ADD:  v = (a31 == b31) & (r31 != a31);
      OP_SUB:  v = (a31 != b31) & (r31 != a31);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  assign need_fix_s   = ((op_r == OP_ADD) && c_lo_r) || ((op_r == OP_SUB) && !c_lo_r);
  assign fin_result_s = {fin_hi_s, lo_r};

  // Next state, ALU drive for the coming cycle, and the final high half/carries entering RESP.
  always_comb begin
    next_state_s = state_r;
    alu_a_s      = 16'h0000;
    alu_b_s      = 16'h0000;
    alu_op_s     = 2'b00;
    fin_hi_s     = hi_r;
    fin_c2_s     = c2_r;
    fin_c3_s     = c3_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          next_state_s = ST_LO;
          alu_a_s      = req_a[15:0];
          alu_b_s      = req_b[15:0];
          alu_op_s     = req_op;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LO: begin
        next_state_s = ST_HI;
        alu_a_s      = a_r[31:16];
        alu_b_s      = b_r[31:16];
        alu_op_s     = op_r;
      end
      ST_HI: begin
        fin_hi_s = alu_result;
        fin_c2_s = alu_carry;
        fin_c3_s = 1'b0;
        if (need_fix_s) begin
          next_state_s = ST_FIX;
          alu_a_s      = alu_result;
          alu_b_s      = 16'h0001;
          alu_op_s     = op_r;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      ST_FIX: begin
        fin_hi_s     = alu_result;
        fin_c3_s     = alu_carry;
        next_state_s = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, operand/partial-result registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      op_r         <= 2'b00;
      a_r          <= 32'h0000_0000;
      b_r          <= 32'h0000_0000;
      lo_r         <= 16'h0000;
      hi_r         <= 16'h0000;
      c_lo_r       <= 1'b0;
      c2_r         <= 1'b0;
      c3_r         <= 1'b0;
      req_ready    <= 1'b1;
      alu_a        <= 16'h0000;
      alu_b        <= 16'h0000;
      alu_op       <= 2'b00;
      rsp_valid    <= 1'b0;
      rsp_result   <= 32'h0000_0000;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_negative <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      req_ready <= (next_state_s == ST_IDLE);
      rsp_valid <= (next_state_s == ST_RESP);
      alu_a     <= alu_a_s;
      alu_b     <= alu_b_s;
      alu_op    <= alu_op_s;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            op_r <= req_op;
            a_r  <= req_a;
            b_r  <= req_b;
          end
        end
        ST_LO: begin
          lo_r   <= alu_result;
          c_lo_r <= alu_carry;
        end
        ST_HI: begin
          hi_r <= alu_result;
          c2_r <= alu_carry;
          c3_r <= 1'b0;
        end
        ST_FIX: begin
          hi_r <= alu_result;
          c3_r <= alu_carry;
        end
        default: begin
        end
      endcase
      if ((state_r != ST_RESP) && (next_state_s == ST_RESP)) begin
        rsp_result   <= fin_result_s;
        rsp_carry    <= calc_carry(op_r, c_lo_r, fin_c2_s, fin_c3_s);
        rsp_overflow <= calc_overflow(op_r, a_r[31], b_r[31], fin_result_s[31]);
        rsp_zero     <= ~|fin_result_s;
        rsp_negative <= fin_result_s[31];
      end
    end
  end

endmodule

// File: tb/tb_alu32_sequencer.sv
// Bench for alu32_sequencer: behavioural 16-bit ALU plus a 32-bit reference model,
// directed corner vectors, randomized requests, response back-pressure and mid-operation reset.
module tb_alu32_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_overflow;
  logic        rsp_zero;
  logic        rsp_negative;

  int n_checks;
  int n_pass;

  alu32_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .rsp_negative (rsp_negative)
  );

  // Stand-in for the external 16-bit ALU; sub carry is 1 when no borrow occurs.
  logic [16:0] alu_wide;
  always_comb begin
    case (alu_op)
      2'b00:   alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   alu_wide = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
      2'b10:   alu_wide = {1'b0, alu_a & alu_b};
      default: alu_wide = {1'b0, alu_a | alu_b};
    endcase
  end
  assign alu_result = alu_wide[15:0];
  assign alu_carry  = (alu_op[1] == 1'b0) ? alu_wide[16] : 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, no knowledge of the split datapath.
  task automatic ref_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic c, output logic v,
                          output int lat);
    logic [32:0] s;
    lat = 3;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
        if ((32'(a[15:0]) + 32'(b[15:0])) > 32'h0000_FFFF) lat = 4;
      end
      2'b01: begin
        r = a - b;
        c = (a >= b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
        if (a[15:0] < b[15:0]) lat = 4;
      end
      2'b10: begin
        r = a & b;
        c = 1'b0;
        v = 1'b0;
      end
      default: begin
        r = a | b;
        c = 1'b0;
        v = 1'b0;
      end
    endcase
  endtask

  // Entered one time unit after a rising edge with the DUT idle.
  task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
    logic [31:0] er;
    logic        ec;
    logic        ev;
    int          elat;
    int          lat;
    logic [31:0] held;
    ref_calc(op, a, b, er, ec, ev, elat);
    check_eq("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    check_eq("lo_alu_a", 32'(alu_a), 32'(a[15:0]));
    check_eq("lo_alu_b", 32'(alu_b), 32'(b[15:0]));
    check_eq("lo_alu_op", 32'(alu_op), 32'(op));
    check_eq("busy_ready", 32'(req_ready), 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) begin
        check_eq("hi_alu_a", 32'(alu_a), 32'(a[31:16]));
        check_eq("hi_alu_b", 32'(alu_b), 32'(b[31:16]));
      end
    end
    check_eq("latency", 32'(lat), 32'(elat));
    check_eq("result", rsp_result, er);
    check_eq("carry", 32'(rsp_carry), 32'(ec));
    check_eq("overflow", 32'(rsp_overflow), 32'(ev));
    check_eq("zero", 32'(rsp_zero), 32'(er == 32'd0));
    check_eq("negative", 32'(rsp_negative), 32'(er[31]));
    check_eq("resp_alu_a", 32'(alu_a), 32'd0);
    held = rsp_result;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_ready", 32'(req_ready), 32'd0);
      check_eq("hold_result", rsp_result, held);
      check_eq("hold_flags", {28'd0, rsp_carry, rsp_overflow, rsp_zero, rsp_negative},
               {28'd0, ec, ev, (er == 32'd0), er[31]});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("post_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_a     = 32'd0;
    req_b     = 32'd0;
    rsp_ready = 1'b0;
    #12;
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_alu", {14'd0, alu_op, alu_a}, 32'd0);
    check_eq("rst_rsp", rsp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req(2'b00, 32'h0000_FFFF, 32'h0000_0001, 0);
    run_req(2'b01, 32'h0000_0000, 32'h0000_0001, 0);
    run_req(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1);
    run_req(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_req(2'b01, 32'h0005_0005, 32'h0005_0005, 0);
    run_req(2'b10, 32'hF0F0_FFFF, 32'h0FF0_1234, 5);
    run_req(2'b11, 32'h1200_0034, 32'h0045_6700, 0);
    run_req(2'b01, 32'h8000_0000, 32'h0000_0001, 2);

    for (int k = 0; k < 150; k++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra[15:0] = 16'hFFFF;
      if ($urandom_range(0, 3) == 0) rb = ra;
      run_req(2'($urandom_range(0, 3)), ra, rb, $urandom_range(0, 2));
    end

    // Abort during the high pass: outputs clear at once and no response follows.
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_a     = 32'h1234_FFFF;
    req_b     = 32'h0000_0001;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_abort_alu_a", 32'(alu_a), 32'h0000_1234);
    rst_n = 1'b0;
    #1;
    check_eq("abort_ready", 32'(req_ready), 32'd1);
    check_eq("abort_valid", 32'(rsp_valid), 32'd0);
    check_eq("abort_alu", {14'd0, alu_op, alu_a}, 32'd0);
    check_eq("abort_alu_b", 32'(alu_b), 32'd0);
    check_eq("abort_rsp", rsp_result, 32'd0);
    check_eq("abort_flags", {28'd0, rsp_carry, rsp_overflow, rsp_zero, rsp_negative}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("no_rsp_after_abort", 32'(rsp_valid), 32'd0);
    end
    check_eq("idle_after_abort", 32'(req_ready), 32'd1);

    run_req(2'b00, 32'h0001_0002, 32'h0003_0004, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
